packet_receiver: RTL



---
 rtl/noc_params.sv | 23 ++
 rtl/packet_sender.sv | 77 +++++++
 rtl/packet_receiver.sv | 98 +++++++++
 3 files changed

// File: rtl/noc_params.sv
// NoC packet geometry and serial-link framing constants shared by the sender and receiver.
package noc_params;
  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int PAYLOAD_SIZE     = 24;
  localparam int PKT_SIZE         = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + PAYLOAD_SIZE;
  localparam int PKT_SIZE_BYTES   = PKT_SIZE / 8;

  localparam logic [7:0] FRAME_FLAG = 8'h7E;
  localparam logic [7:0] FRAME_ESC  = 8'h7D;
  localparam logic [7:0] ESC_XOR    = 8'h20;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
    logic [PAYLOAD_SIZE-1:0]     payload;
  } packet_t;

  // Bytes that collide with framing and must travel escaped.
  function automatic logic is_special(input logic [7:0] b);
    return (b == FRAME_FLAG) || (b == FRAME_ESC);
  endfunction
endpackage

// File: rtl/packet_sender.sv
// Serial packet sender: frames a packet_t as 7E, escaped bytes MSB-first, 7E; one byte per cycle.
// Accepts a new packet only while ready is high; latency from send to first byte is one cycle.
module packet_sender
  import noc_params::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  packet_t    pkt_in,
  input  logic       send,
  output logic       ready,
  output logic [7:0] tx_byte,
  output logic       tx_valid
);
  localparam int CW = $clog2(PKT_SIZE_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(PKT_SIZE_BYTES - 1);

  typedef enum logic [1:0] {T_IDLE, T_DATA, T_ESC2, T_CLOSE} tstate_t;

  tstate_t             state;
  logic [PKT_SIZE-1:0] sreg;
  logic [CW-1:0]       idx;
  logic [7:0]          head;

  assign head  = sreg[PKT_SIZE-1 -: 8];
  assign ready = (state == T_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= T_IDLE;
      sreg     <= '0;
      idx      <= '0;
      tx_byte  <= '0;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        T_IDLE: begin
          tx_valid <= send;
          if (send) begin
            sreg    <= pkt_in;
            tx_byte <= FRAME_FLAG;
            idx     <= '0;
            state   <= T_DATA;
          end
        end
        T_DATA: begin
          tx_valid <= 1'b1;
          if (is_special(head)) begin
            tx_byte <= FRAME_ESC;
            state   <= T_ESC2;
          end else begin
            tx_byte <= head;
            sreg    <= sreg << 8;
            if (idx == LAST) state <= T_CLOSE;
            else idx <= idx + CW'(1);
          end
        end
        T_ESC2: begin
          tx_valid <= 1'b1;
          tx_byte  <= head ^ ESC_XOR;
          sreg     <= sreg << 8;
          if (idx == LAST) begin
            state <= T_CLOSE;
          end else begin
            idx   <= idx + CW'(1);
            state <= T_DATA;
          end
        end
        T_CLOSE: begin
          tx_valid <= 1'b1;
          tx_byte  <= FRAME_FLAG;
          state    <= T_IDLE;
        end
        default: state <= T_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/packet_receiver.sv
// Serial packet receiver: deframes/unescapes the link byte stream into packet_t, drops malformed frames.
// valid_out/err pulse one cycle after the deciding byte; no backpressure, one byte per cycle sustained.
module packet_receiver
  import noc_params::*;
#(
  parameter bit STRICT_ESC = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       valid_in,
  output packet_t    pkt,
  output logic       valid_out,
  output logic       err,
  output logic       busy
);
  localparam int CW = $clog2(PKT_SIZE_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(PKT_SIZE_BYTES - 1);

  typedef enum logic [1:0] {S_HUNT, S_DATA, S_ESC, S_END} state_t;

  state_t              state;
  logic [CW-1:0]       count;
  logic [PKT_SIZE-1:0] shift_reg;
  logic [7:0]          d;

  assign d    = rx_byte ^ ESC_XOR;
  assign busy = (state != S_HUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HUNT;
      count     <= '0;
      shift_reg <= '0;
      pkt       <= '0;
      valid_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      err       <= 1'b0;
      if (valid_in) begin
        case (state)
          S_HUNT: begin
            if (rx_byte == FRAME_FLAG) begin
              state <= S_DATA;
              count <= '0;
            end
          end
          S_DATA: begin
            if (rx_byte == FRAME_FLAG) begin
              // A flag mid-frame aborts it and opens the next one.
              if (count != '0) begin
                err   <= 1'b1;
                count <= '0;
              end
            end else if (rx_byte == FRAME_ESC) begin
              state <= S_ESC;
            end else begin
              shift_reg <= {shift_reg[PKT_SIZE-9:0], rx_byte};
              if (count == LAST) state <= S_END;
              else count <= count + CW'(1);
            end
          end
          S_ESC: begin
            if (rx_byte == FRAME_FLAG) begin
              err   <= 1'b1;
              count <= '0;
              state <= S_DATA;
            end else if (STRICT_ESC && !is_special(d)) begin
              err   <= 1'b1;
              count <= '0;
              state <= S_HUNT;
            end else begin
              shift_reg <= {shift_reg[PKT_SIZE-9:0], d};
              if (count == LAST) begin
                state <= S_END;
              end else begin
                count <= count + CW'(1);
                state <= S_DATA;
              end
            end
          end
          S_END: begin
            if (rx_byte == FRAME_FLAG) begin
              pkt       <= packet_t'(shift_reg);
              valid_out <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            count <= '0;
            state <= S_HUNT;
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end
endmodule
